keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Drives the 4x4 matrix keypad and produces the debounced key code consumed
//  by the turn logic (its keypad_in). Rotates an active-low column strobe,
//  samples synchronised active-low rows, and debounces press and release.
//  Emits one key_valid strobe per physical press. Sits between board pins
//  and the game core.
// PARAMETERS
//  SCAN_DIV      1000  clocks per column dwell (one "tick"); must be >= 4
//  DEBOUNCE_CNT  8     consecutive stable ticks needed to accept press/release; >= 1
// PORTS
//  clk        in   1  system clock
//  rst        in   1  asynchronous, active-low reset
//  row_in     in   4  keypad rows, active-low (board pull-ups), asynchronous
//  col_out    out  4  column strobe, active-low, at most one bit low
//  key_scan   out  4  code of last accepted key = row*4 + col (0..15), held
//  key_valid  out  1  1-cycle strobe: key_scan updated with a new press
//  key_down   out  1  level: debounced key currently held
// BEHAVIOUR
//  Reset (rst=0, async): col_out=4'b1110 (col 0), key_scan=0, key_valid=0,
//   key_down=0, state=SCAN, tick and debounce counters = 0, sync flops = 4'hF.
//  row_in passes a 2-flop synchroniser; rows are sampled as rs = ~row_sync.
//  Tick: divider counts 0..SCAN_DIV-1; tick asserts on the last count. Rows
//   are sampled only on tick, so col_out is >= SCAN_DIV-1 clocks stable first.
//  Row priority: several rows low in one column -> lowest row index wins.
//   Only the current column is ever considered.
//  FSM:
//   SCAN:    on tick, rs==0 -> advance column (3 wraps to 0, col_out
//            rotates 1110->1101->1011->0111->1110). rs!=0 -> latch
//            cand_row, cnt=1, go DB_PRESS. The column holds.
//   DB_PRESS: on tick, cand_row still pressed -> cnt++. Otherwise -> SCAN,
//            advance column. Reaching cnt==DEBOUNCE_CNT -> PRESSED. With
//            DEBOUNCE_CNT==1, the SCAN tick goes straight to PRESSED.
//   PRESSED entry (same clock as transition): key_scan={cand_row,col},
//            key_valid=1 for exactly that clock, key_down=1.
//   PRESSED: column frozen. On tick, rs==0 -> cnt=1, go DB_REL. Other
//            rows pressed additionally -> ignored (no new strobe).
//   DB_REL:  on tick, rs==0 -> cnt++. Any row low -> back to PRESSED, no
//            strobe. Reaching cnt==DEBOUNCE_CNT -> key_down=0, advance
//            column, SCAN.
//  key_scan is never cleared after reset; it holds the last accepted key.
//  Key held indefinitely: a single key_valid; no auto-repeat.
//  Latency: physical press (stable) -> key_valid in
//   <= 4*SCAN_DIV + DEBOUNCE_CNT*SCAN_DIV + 3 clocks.
//  Reset mid-operation (any state): immediate return to reset values. A key
//   still held after reset release is detected again as a new press.
//  Divider and counters saturate/wrap safely; no X on outputs after reset.
// TESTING  (SCAN_DIV=4, DEBOUNCE_CNT=3)
//  1 Idle, rows=4'hF -> col_out cycles 1110,1101,1011,0111 every 4 clks; never
//    key_valid; key_down=0.
//  2 Hold row2 low while col1 strobed (key 9) -> one key_valid, key_scan=9,
//    key_down=1. Release -> key_down=0 after 3 ticks; scanning resumes at col2.
//  3 Press key 9 for only 2 ticks -> no key_valid; key_scan keeps old value.
//  4 Key 9 held, release glitch of 1 tick -> no second strobe, key_down stays
//    1. Final release -> exactly one strobe total.
//  5 Rows 1 and 3 low in col3 -> key_scan=7 (row1 wins). While held, add
//    key 0 -> no strobe.
//  6 rst=0 in DB_PRESS and in PRESSED -> outputs and col_out=1110 at once.
//    Key held through rst release -> fresh key_valid with the same code.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Debounced key-code interface between the keypad scanner and its consumer.
// The scanner drives through the master modport; the turn logic reads through the slave modport.
interface keypad_scanner_if;
  logic [3:0] key_scan;
  logic       key_valid;
  logic       key_down;

  modport master (output key_scan, output key_valid, output key_down);
  modport slave  (input  key_scan, input  key_valid, input  key_down);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotating active-low column strobe, synchronised rows,
// press/release debounce in column-dwell ticks, one key_valid strobe per accepted press.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        row_in,
  output logic [3:0]        col_out,
  keypad_scanner_if.master  key
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {SCAN, DB_PRESS, PRESSED, DB_REL} state_t;

  state_t           state, state_n;
  logic [3:0]       row_meta, row_sync;
  logic [DIV_W-1:0] div;
  logic [1:0]       col, col_n;
  logic [1:0]       cand_row, cand_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]       key_scan_q, scan_n;
  logic             key_valid_q, valid_n;
  logic             key_down_q, down_n;
  logic [3:0]       rs;
  logic             tick, hit, cand_hit;
  logic [1:0]       first_row;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta <= '1;
      row_sync <= '1;
      div      <= '0;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
      div      <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  assign tick    = (div == DIV_LAST);
  assign rs      = ~row_sync;
  assign hit     = |rs;
  assign cand_hit = rs[cand_row];
  assign cnt_inc = cnt + 1'b1;

  // Lowest row index wins when several rows are low in the strobed column.
  always_comb begin
    first_row = 2'd3;
    if (rs[0])      first_row = 2'd0;
    else if (rs[1]) first_row = 2'd1;
    else if (rs[2]) first_row = 2'd2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SCAN;
      col         <= '0;
      cand_row    <= '0;
      cnt         <= '0;
      key_scan_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state       <= state_n;
      col         <= col_n;
      cand_row    <= cand_n;
      cnt         <= cnt_n;
      key_scan_q  <= scan_n;
      key_valid_q <= valid_n;
      key_down_q  <= down_n;
    end
  end

  always_comb begin
    state_n = state;
    col_n   = col;
    cand_n  = cand_row;
    cnt_n   = cnt;
    scan_n  = key_scan_q;
    valid_n = 1'b0;
    down_n  = key_down_q;
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (!hit) begin
            col_n = col + 2'd1;
          end else begin
            cand_n = first_row;
            cnt_n  = CNT_ONE;
            if (DEBOUNCE_CNT == 1) begin
              state_n = PRESSED;
              scan_n  = {first_row, col};
              valid_n = 1'b1;
              down_n  = 1'b1;
            end else begin
              state_n = DB_PRESS;
            end
          end
        end
        DB_PRESS: begin
          if (cand_hit) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_n = PRESSED;
              scan_n  = {cand_row, col};
              valid_n = 1'b1;
              down_n  = 1'b1;
            end
          end else begin
            state_n = SCAN;
            col_n   = col + 2'd1;
          end
        end
        PRESSED: begin
          if (!hit) begin
            cnt_n = CNT_ONE;
            if (DEBOUNCE_CNT == 1) begin
              state_n = SCAN;
              down_n  = 1'b0;
              col_n   = col + 2'd1;
            end else begin
              state_n = DB_REL;
            end
          end
        end
        DB_REL: begin
          if (!hit) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_n = SCAN;
              down_n  = 1'b0;
              col_n   = col + 2'd1;
            end
          end else begin
            state_n = PRESSED;
          end
        end
      endcase
    end
  end

  assign col_out       = ~(4'b0001 << col);
  assign key.key_scan  = key_scan_q;
  assign key.key_valid = key_valid_q;
  assign key.key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3) with a behavioural 4x4 keypad model.
module tb_keypad_scanner;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] keys = '0;
  int          tests = 0;
  int          fails = 0;
  int          vcnt = 0;

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .row_in  (row_in),
    .col_out (col_out),
    .key     (kif)
  );

  always #5 clk = ~clk;

  // Pressed key r*4+c pulls row r low while column c is strobed low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(posedge clk) if (kif.key_valid === 1'b1) vcnt++;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, required finish before 500us");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (kif.key_valid === 1'b1) break;
    end
    chk(tag, kif.key_valid, 1'b1);
  endtask

  task automatic wait_release(input string tag, input int bound, output int n);
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (kif.key_down === 1'b0) break;
    end
    chk(tag, kif.key_down, 1'b0);
  endtask

  task automatic wait_col_change(input string tag, input int bound, output int n);
    logic [3:0] prev;
    prev = col_out;
    n = 0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (col_out !== prev) break;
    end
    chk(tag, (col_out !== prev), 1'b1);
  endtask

  // Returns at the negedge right after the column strobe moves onto column 1.
  task automatic wait_col1_entry(input string tag);
    int n;
    n = 0;
    while (col_out === 4'b1101 && n < 40) begin @(negedge clk); n++; end
    while (col_out !== 4'b1101 && n < 40) begin @(negedge clk); n++; end
    chk(tag, col_out, 4'b1101);
  endtask

  initial begin
    int n, v0;
    logic held;
    logic [3:0] exp_cols [4];
    exp_cols[0] = 4'b1101; exp_cols[1] = 4'b1011;
    exp_cols[2] = 4'b0111; exp_cols[3] = 4'b1110;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_col", col_out, 4'b1110);
    chk("rst_scan", kif.key_scan, 4'd0);
    chk("rst_valid", kif.key_valid, 1'b0);
    chk("rst_down", kif.key_down, 1'b0);
    rst = 1'b1;

    // 1: idle rotation, one column step every 4 clocks
    for (int i = 0; i < 4; i++) begin
      wait_col_change("idle_change", 10, n);
      chk("idle_period", n, 4);
      chk("idle_col", col_out, exp_cols[i]);
    end
    repeat (20) @(negedge clk);
    chk("idle_no_valid", vcnt, 0);
    chk("idle_down", kif.key_down, 1'b0);

    // 2: key 9 (row2, col1) press and release
    keys[9] = 1'b1;
    wait_valid("k9_valid", 60, n);
    chk("k9_latency_ok", (n <= 31), 1'b1);
    chk("k9_scan", kif.key_scan, 4'd9);
    chk("k9_down", kif.key_down, 1'b1);
    chk("k9_col_frozen", col_out, 4'b1101);
    @(negedge clk);
    chk("k9_valid_1cyc", kif.key_valid, 1'b0);
    repeat (30) @(negedge clk);
    chk("k9_one_strobe", vcnt, 1);
    chk("k9_still_down", kif.key_down, 1'b1);
    keys = '0;
    wait_release("k9_release", 40, n);
    chk("k9_rel_window", (n >= 11 && n <= 14), 1'b1);
    chk("k9_resume_col2", col_out, 4'b1011);

    // 5: rows 1 and 3 in col3 -> key 7; extra key 0 ignored while held
    v0 = vcnt;
    keys[7] = 1'b1;
    keys[15] = 1'b1;
    wait_valid("k7_valid", 60, n);
    chk("k7_scan", kif.key_scan, 4'd7);
    keys[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("k7_no_extra", vcnt - v0, 1);
    chk("k7_down", kif.key_down, 1'b1);
    chk("k7_scan_hold", kif.key_scan, 4'd7);
    keys = '0;
    wait_release("k7_release", 40, n);

    // 3: key 9 held for only 2 ticks
    v0 = vcnt;
    wait_col1_entry("short_col1");
    keys[9] = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    keys = '0;
    repeat (40) @(negedge clk);
    chk("short_no_valid", vcnt - v0, 0);
    chk("short_scan_kept", kif.key_scan, 4'd7);
    chk("short_down", kif.key_down, 1'b0);

    // 4: release glitch seen on a single tick
    v0 = vcnt;
    keys[9] = 1'b1;
    wait_valid("gl_valid", 60, n);
    chk("gl_scan", kif.key_scan, 4'd9);
    held = 1'b1;
    for (int i = 0; i < 4; i++) begin @(negedge clk); held &= kif.key_down; end
    keys = '0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); held &= kif.key_down; end
    keys[9] = 1'b1;
    for (int i = 0; i < 16; i++) begin @(negedge clk); held &= kif.key_down; end
    chk("gl_down_held", held, 1'b1);
    chk("gl_no_second", vcnt - v0, 1);
    keys = '0;
    wait_release("gl_release", 40, n);
    repeat (10) @(negedge clk);
    chk("gl_total_one", vcnt - v0, 1);

    // 6: reset in DB_PRESS, then in PRESSED, key held through release
    wait_col1_entry("rst_col1");
    keys[9] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rdb_col", col_out, 4'b1110);
    chk("rdb_scan", kif.key_scan, 4'd0);
    chk("rdb_down", kif.key_down, 1'b0);
    chk("rdb_valid", kif.key_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    wait_valid("rdb_revalid", 60, n);
    chk("rdb_rescan", kif.key_scan, 4'd9);
    repeat (3) @(negedge clk);
    chk("rpr_down_before", kif.key_down, 1'b1);
    rst = 1'b0;
    #1;
    chk("rpr_col", col_out, 4'b1110);
    chk("rpr_scan", kif.key_scan, 4'd0);
    chk("rpr_down", kif.key_down, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    wait_valid("rpr_revalid", 60, n);
    chk("rpr_rescan", kif.key_scan, 4'd9);
    keys = '0;
    wait_release("rpr_release", 40, n);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
